// File: rtl/mips_memory_unit.sv
// Memory stage that decodes each strobe to RAM, two latched input ports, or an output port.
// Reads take 1 cycle, then rd_data holds until the next read. There is no backpressure: one access per strobe.
module mips_memory_unit #(
    parameter int          RAM_DEPTH    = 256,
    parameter logic [31:0] INPORT0_ADDR = 32'h0000FFF8,
    parameter logic [31:0] INPORT1_ADDR = 32'h0000FFFC,
    parameter logic [31:0] OUTPORT_ADDR = 32'h0000FFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] inport_data,
    input  logic        inport0_en,
    input  logic        inport1_en,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic [31:0] outport,
    output logic [1:0]  err
);

    localparam int          AW        = $clog2(RAM_DEPTH);
    localparam logic [29:0] RAM_WORDS = 30'(RAM_DEPTH);

    typedef enum logic {IDLE, RD_PEND} state_t;

    logic [31:0] mem [RAM_DEPTH];
    logic [31:0] inport0_reg;
    logic [31:0] inport1_reg;
    state_t      state;

    logic [29:0]   word;
    logic [AW-1:0] idx;
    logic          hit_ram;
    logic          hit_in0;
    logic          hit_in1;
    logic          hit_out;
    logic          rd_go;
    logic          misaligned;
    logic          unmapped_rd;
    logic          unmapped_wr;
    logic          collide;
    logic [31:0]   rd_mux;

    // Byte offset is ignored for decode; misaligned accesses still hit the word.
    assign word    = addr[31:2];
    assign idx     = addr[AW+1:2];
    assign hit_ram = (word < RAM_WORDS);
    assign hit_in0 = !hit_ram && (word == INPORT0_ADDR[31:2]);
    assign hit_in1 = !hit_ram && (word == INPORT1_ADDR[31:2]);
    assign hit_out = !hit_ram && (word == OUTPORT_ADDR[31:2]);

    assign collide     = MemRead && MemWrite;
    assign rd_go       = MemRead && !MemWrite;
    assign misaligned  = (MemRead || MemWrite) && (addr[1:0] != 2'b00);
    assign unmapped_rd = rd_go && !(hit_ram || hit_in0 || hit_in1);
    assign unmapped_wr = MemWrite && !(hit_ram || hit_in0 || hit_in1 || hit_out);

    always_comb begin
        rd_mux = 32'h0;
        if (hit_ram)
            rd_mux = mem[idx];
        else if (hit_in0)
            rd_mux = inport0_reg;
        else if (hit_in1)
            rd_mux = inport1_reg;
    end

    // Written at the strobe edge, so a registered read on the next edge sees the new word.
    always_ff @(posedge clk) begin
        if (!rst && MemWrite && hit_ram)
            mem[idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rd_data     <= 32'h0;
            outport     <= 32'h0;
            err         <= 2'b00;
            inport0_reg <= 32'h0;
            inport1_reg <= 32'h0;
        end else begin
            state <= rd_go ? RD_PEND : IDLE;
            if (rd_go)
                rd_data <= rd_mux;
            if (MemWrite && hit_out)
                outport <= wr_data;
            if (misaligned)
                err[0] <= 1'b1;
            if (unmapped_rd || unmapped_wr || collide)
                err[1] <= 1'b1;
            if (inport0_en)
                inport0_reg <= inport_data;
            if (inport1_en)
                inport1_reg <= inport_data;
        end
    end

    assign rd_valid = (state == RD_PEND);

endmodule

// File: tb/tb_mips_memory_unit.sv
// Randomized bench for mips_memory_unit with a behavioural reference model and directed anchor checks.
module tb_mips_memory_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] inport_data;
    logic        inport0_en;
    logic        inport1_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [31:0] outport;
    logic [1:0]  err;

    mips_memory_unit dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wr_data    (wr_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .inport_data(inport_data),
        .inport0_en (inport0_en),
        .inport1_en (inport1_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .outport    (outport),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_ram   [256];
    bit          m_known [256];
    logic [31:0] m_rd;
    bit          m_rd_known;
    bit          m_valid;
    logic [31:0] m_out;
    logic [1:0]  m_err;
    logic [31:0] m_in0;
    logic [31:0] m_in1;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 = RAM, 1 = input port 0, 2 = input port 1 / output port, 3 = unmapped
    function automatic int target(input logic [31:0] a);
        if (a < 32'd1024) return 0;
        if ((a & ~32'd3) == 32'h0000FFF8) return 1;
        if ((a & ~32'd3) == 32'h0000FFFC) return 2;
        return 3;
    endfunction

    task automatic model_clock();
        int t;
        int i;
        logic [31:0] old_in0;
        logic [31:0] old_in1;
        if (rst) begin
            m_rd = 0; m_rd_known = 1; m_valid = 0;
            m_out = 0; m_err = 0; m_in0 = 0; m_in1 = 0;
            return;
        end
        t = target(addr);
        i = int'(addr >> 2) % 256;
        old_in0 = m_in0;
        old_in1 = m_in1;
        m_valid = 0;
        if ((MemRead || MemWrite) && addr[1:0] != 2'b00) m_err[0] = 1'b1;
        if (MemRead && MemWrite) m_err[1] = 1'b1;
        if (MemWrite) begin
            if (t == 0) begin m_ram[i] = wr_data; m_known[i] = 1; end
            else if (t == 2) m_out = wr_data;
            else if (t == 3) m_err[1] = 1'b1;
        end
        if (MemRead && !MemWrite) begin
            m_valid = 1;
            m_rd_known = 1;
            case (t)
                0: begin m_rd = m_ram[i]; m_rd_known = m_known[i]; end
                1: m_rd = old_in0;
                2: m_rd = old_in1;
                default: begin m_rd = 0; m_err[1] = 1'b1; end
            endcase
        end
        if (inport0_en) m_in0 = inport_data;
        if (inport1_en) m_in1 = inport_data;
    endtask

    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] wd,
                        input logic mr, input logic mw, input logic [31:0] ind,
                        input logic e0, input logic e1);
        rst = r; addr = a; wr_data = wd; MemRead = mr; MemWrite = mw;
        inport_data = ind; inport0_en = e0; inport1_en = e1;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle();                                 step(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d); step(0, a, d, 0, 1, 0, 0, 0); endtask
    task automatic rd(input logic [31:0] a);               step(0, a, 0, 1, 0, 0, 0, 0); endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rd_valid", {31'b0, rd_valid}, {31'b0, m_valid});
            check("outport", outport, m_out);
            check("err", {30'b0, err}, {30'b0, m_err});
            if (m_rd_known) check("rd_data", rd_data, m_rd);
        end
    end

    initial begin
        for (int k = 0; k < 256; k++) begin m_ram[k] = 0; m_known[k] = 0; end
        m_rd = 0; m_rd_known = 0; m_valid = 0; m_out = 0; m_err = 0; m_in0 = 0; m_in1 = 0;

        // Reset held two cycles
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h10, 32'h1, 1, 1, 32'h5, 1, 1);
        chk_en = 1'b1;
        idle();
        @(negedge clk);
        check("reset rd_data", rd_data, 32'h0);
        check("reset rd_valid", {31'b0, rd_valid}, 32'h0);
        check("reset outport", outport, 32'h0);
        check("reset err", {30'b0, err}, 32'h0);

        // RAM write then read-after-write
        wr(32'h10, 32'hDEADBEEF);
        rd(32'h10);
        @(negedge clk);
        check("raw rd_data", rd_data, 32'hDEADBEEF);
        check("raw rd_valid", {31'b0, rd_valid}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            idle();
            @(negedge clk);
            check("hold rd_data", rd_data, 32'hDEADBEEF);
            check("hold rd_valid", {31'b0, rd_valid}, 32'h0);
        end

        // Input ports
        step(0, 0, 0, 0, 0, 32'h1FF, 1, 0);
        step(0, 0, 0, 0, 0, 32'h0AA, 0, 1);
        rd(32'hFFF8);
        @(negedge clk);
        check("inport0", rd_data, 32'h1FF);
        rd(32'hFFFC);
        @(negedge clk);
        check("inport1", rd_data, 32'h0AA);

        // Output port shares its address with input port 1
        wr(32'hFFFC, 32'h5);
        @(negedge clk);
        check("outport write", outport, 32'h5);
        rd(32'hFFFC);
        @(negedge clk);
        check("shared addr read", rd_data, 32'h0AA);
        check("no err yet", {30'b0, err}, 32'h0);

        // Unmapped read, misaligned write
        rd(32'h00002000);
        @(negedge clk);
        check("unmapped rd_data", rd_data, 32'h0);
        check("unmapped err", {30'b0, err}, 32'h2);
        wr(32'h3, 32'h1234);
        @(negedge clk);
        check("misaligned err", {30'b0, err}, 32'h3);
        rd(32'h0);
        @(negedge clk);
        check("misaligned wrote word0", rd_data, 32'h1234);

        // Simultaneous read and write
        step(0, 32'h8, 32'h7, 1, 1, 0, 0, 0);
        @(negedge clk);
        check("collide rd_valid", {31'b0, rd_valid}, 32'h0);
        check("collide rd_data", rd_data, 32'h1234);
        check("collide err", {30'b0, err}, 32'h3);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("reset clears err", {30'b0, err}, 32'h0);
        rd(32'h8);
        @(negedge clk);
        check("ram survives reset", rd_data, 32'h7);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic mr, mw;
            int sel, op;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 255)) << 2;
                6: a = 32'h0000FFF8;
                7: a = 32'h0000FFFC;
                8: a = $urandom | 32'h00010000;
                default: a = $urandom_range(0, 1023);
            endcase
            op = $urandom_range(0, 15);
            mr = (op < 6) || (op == 15);
            mw = (op >= 6 && op < 11) || (op == 15);
            step(($urandom_range(0, 99) == 0), a, $urandom, mr, mw, $urandom,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        idle();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
